mp_feed_arbiter: RTL and testbench

Clocked round-robin arbiter that shares the input port of the asynchronous micropipeline FIFO (`stage_all`) between up to four clocked producers. It accepts one word at a time over a valid/ready interface, drives the pipeline's `req_in`/`data_in` with a four-phase return-to-zero handshake, and completes each transfer against the pipeline's `ack_out`. It sits between the synchronous producer logic and the self-timed pipeline, and flags stalled handshakes with a timeout.

---
 rtl/mp_feed_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mp_feed_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_feed_arbiter.sv
// mp_feed_arbiter: round-robin arbiter that feeds one word at a time from up to
// four clocked producers into an asynchronous micropipeline. It uses a four-phase
// return-to-zero req/ack handshake and raises a sticky flag when a handshake stalls.
// Build option: define MP_ACK_SYNC_EN to pass mp_ack through a two-flop synchronizer.
// Leave it undefined when the pipeline ack is already synchronous to clk.

module mp_feed_arbiter #(
    parameter int unsigned DATA_WIDTH  = 3,
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            src_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
    output logic [NUM_REQ-1:0]            src_ready,
    output logic                          mp_req,
    output logic [DATA_WIDTH-1:0]         mp_data,
    input  logic                          mp_ack,
    output logic [1:0]                    grant_id,
    output logic                          busy,
    output logic                          timeout_err,
    input  logic                          clr_err
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned ID_W  = 2;
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [ID_W-1:0]  LAST_RST    = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RTZ  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  mp_req_q, mp_req_d;
    logic [DATA_WIDTH-1:0] mp_data_q, mp_data_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  ack_s;
    logic                  hi_found, lo_found;
    logic [ID_W-1:0]       hi_idx, lo_idx;
    logic                  arb_any;
    logic [ID_W-1:0]       arb_sel;
    logic [DATA_WIDTH-1:0] arb_word;
    logic [NUM_REQ-1:0]    ready_vec;
    logic                  accept;
    logic                  set_err;

`ifdef MP_ACK_SYNC_EN
    logic [1:0] ack_sync_q, ack_sync_d;

    // Two-flop synchronizer for the self-timed ack
    always_comb begin
        ack_sync_d = {ack_sync_q[0], mp_ack};
    end

    // Synchronizer flops, cleared with the rest of the block
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_sync_q <= 2'b00;
        end else begin
            ack_sync_q <= ack_sync_d;
        end
    end

    assign ack_s = ack_sync_q[1];
`else
    assign ack_s = mp_ack;
`endif

    // Round-robin pick: first valid index above the last grant, else wrap to the lowest valid
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (src_valid[i] && !hi_found && (i > int'(last_q))) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
            if (src_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
        end
        arb_any = lo_found;
        arb_sel = hi_found ? hi_idx : lo_idx;
    end

    // Select the granted word and build the one-hot ready, only offered in IDLE
    always_comb begin
        arb_word  = '0;
        ready_vec = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (ID_W'(i) == arb_sel) begin
                arb_word     = src_data[i*DATA_WIDTH +: DATA_WIDTH];
                ready_vec[i] = arb_any && (state_q == ST_IDLE);
            end
        end
    end

    // Ready is forced low while reset is asserted so no word is taken during reset
    assign src_ready = rst_n ? ready_vec : '0;
    assign accept    = arb_any && (state_q == ST_IDLE);

    // Handshake sequencing, stall counter and sticky error flag
    always_comb begin
        state_d   = state_q;
        mp_req_d  = mp_req_q;
        mp_data_d = mp_data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        set_err   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mp_data_d = arb_word;
                    mp_req_d  = 1'b1;
                    grant_d   = arb_sel;
                    last_d    = arb_sel;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    mp_req_d = 1'b0;
                    state_d  = ST_RTZ;
                end
            end
            ST_RTZ: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mp_req_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Counter measures time spent in one waiting phase; it restarts on any state change
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q != ST_IDLE) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Flag only on the cycle the count reaches the limit, so a saturated count cannot re-arm it
        set_err = (state_q != ST_IDLE) && (state_d == state_q) &&
                  (cnt_d == TIMEOUT_VAL) && (cnt_q != TIMEOUT_VAL);

        if (set_err) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mp_req_q  <= 1'b0;
            mp_data_q <= '0;
            grant_q   <= '0;
            last_q    <= LAST_RST;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mp_req_q  <= mp_req_d;
            mp_data_q <= mp_data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mp_req      = mp_req_q;
    assign mp_data     = mp_data_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_mp_feed_arbiter.sv
// Bench for mp_feed_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (round-robin choice, ack-to-req latency, bundled data).

module tb_mp_feed_arbiter;

    localparam int unsigned DW   = 3;
    localparam int unsigned NREQ = 2;
    localparam int unsigned TMO  = 8;
`ifdef MP_ACK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    src_valid;
    logic [NREQ*DW-1:0] src_data;
    logic [NREQ-1:0]    src_ready;
    logic               mp_req;
    logic [DW-1:0]      mp_data;
    logic               mp_ack;
    logic [1:0]         grant_id;
    logic               busy;
    logic               timeout_err;
    logic               clr_err;

    int total;
    int bad;
    int last_m;

    mp_feed_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NREQ),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .mp_req     (mp_req),
        .mp_data    (mp_data),
        .mp_ack     (mp_ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first valid index after the previous grant, wrapping
    function automatic int pick(input logic [NREQ-1:0] v);
        for (int off = 1; off <= int'(NREQ); off++) begin
            int idx;
            idx = (last_m + off) % int'(NREQ);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Lanes not currently offering a word may change freely
    task automatic scramble();
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!src_valid[i]) src_data[i*DW +: DW] = DW'($urandom);
        end
    endtask

    // Raise ack, expect req to drop LAT+1 edges later, then release ack and expect IDLE LAT+1 edges later
    task automatic finish_hs(input logic [DW-1:0] word, input int fall_d);
        mp_ack = 1'b1;
        for (int i = 0; i <= LAT; i++) begin
            scramble();
            step();
            chk("req_fall", mp_req, (i == LAT) ? 0 : 1);
            chk("hold_data", mp_data, word);
            chk("ready_hs", src_ready, 0);
            chk("busy_req", busy, 1);
        end
        for (int i = 0; i < fall_d; i++) begin
            scramble();
            step();
            chk("rtz_req", mp_req, 0);
            chk("busy_rtz", busy, 1);
            chk("hold_data", mp_data, word);
        end
        mp_ack = 1'b0;
        for (int i = 0; i <= LAT; i++) begin
            scramble();
            step();
            chk("busy_fall", busy, (i == LAT) ? 0 : 1);
            chk("hold_data", mp_data, word);
            if (i < LAT) chk("ready_rtz", src_ready, 0);
        end
    endtask

    // One complete transfer from whatever valids are currently presented
    task automatic xfer(input int rise_d, input int fall_d, output int g);
        logic [DW-1:0] word;
        #1;
        g = pick(src_valid);
        if (g < 0) begin
            chk("xfer_valid", 0, 1);
            return;
        end
        chk("ready_acc", src_ready, 32'(1) << g);
        word = src_data[g*DW +: DW];
        step();
        chk("ready_off", src_ready, 0);
        src_valid[g] = 1'b0;
        last_m = g;
        chk("req_rise", mp_req, 1);
        chk("data_acc", mp_data, word);
        chk("grant", grant_id, g);
        chk("busy_rise", busy, 1);
        for (int i = 0; i < rise_d; i++) begin
            scramble();
            step();
            chk("req_hold", mp_req, 1);
            chk("hold_data", mp_data, word);
            chk("ready_hs", src_ready, 0);
        end
        finish_hs(word, fall_d);
        chk("no_tmo", timeout_err, 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mp_ack    = 1'b0;
        src_valid = '0;
        step();
        chk("rst_busy", busy, 0);
        rst_n  = 1'b1;
        last_m = int'(NREQ) - 1;
    endtask

    initial begin
        int g;
        total     = 0;
        bad       = 0;
        last_m    = int'(NREQ) - 1;
        rst_n     = 1'b0;
        mp_ack    = 1'b0;
        clr_err   = 1'b0;
        src_data  = '0;
        src_valid = 2'b01;
        src_data[0 +: DW] = 3'd5;

        // Reset, then a single word from requester 0
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_req", mp_req, 0);
            chk("rst_data", mp_data, 0);
            chk("rst_grant", grant_id, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tmo", timeout_err, 0);
            chk("rst_ready", src_ready, 0);
        end
        rst_n = 1'b1;
        xfer(0, 0, g);
        chk("single_data", mp_data, 5);

        // Round-robin between two always-valid requesters
        do_reset();
        src_valid = 2'b11;
        src_data[0 +: DW]  = 3'd1;
        src_data[DW +: DW] = 3'd2;
        for (int k = 0; k < 4; k++) begin
            xfer(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), g);
            chk("rr_grant", grant_id, k % 2);
            chk("rr_data", mp_data, (k % 2) + 1);
            if (g >= 0) begin
                src_valid[g] = 1'b1;
                src_data[g*DW +: DW] = DW'(g + 1);
            end
        end
        src_valid = '0;
        step();

        // Timeout with no ack, then clear and complete
        src_valid = 2'b01;
        src_data[0 +: DW] = 3'd6;
        #1;
        chk("tmo_ready", src_ready, 1);
        step();
        src_valid = '0;
        last_m = 0;
        chk("tmo_req0", mp_req, 1);
        for (int i = 1; i <= 11; i++) begin
            step();
            chk("tmo_flag", timeout_err, (i >= int'(TMO)) ? 1 : 0);
            chk("tmo_req", mp_req, 1);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("tmo_clr", timeout_err, 0);
        finish_hs(3'd6, 1);
        chk("tmo_after", timeout_err, 0);

        // Clear on the same edge the timeout fires: set wins
        src_valid = 2'b01;
        src_data[0 +: DW] = 3'd7;
        #1;
        step();
        src_valid = '0;
        last_m = 0;
        for (int i = 1; i < int'(TMO); i++) begin
            step();
            chk("tmo2_flag", timeout_err, 0);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("tmo_set_wins", timeout_err, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("tmo_clr2", timeout_err, 0);
        finish_hs(3'd7, 0);

        // Reset while in REQ: word dropped, requester 0 regains priority
        src_valid = 2'b01;
        src_data[0 +: DW] = 3'd3;
        #1;
        chk("mid_ready", src_ready, 1);
        step();
        chk("mid_req", mp_req, 1);
        src_valid = 2'b11;
        src_data[DW +: DW] = 3'd4;
        step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_req", mp_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", mp_data, 0);
        chk("mid_rst_ready", src_ready, 0);
        rst_n  = 1'b1;
        last_m = int'(NREQ) - 1;
        #1;
        chk("rst_prio", src_ready, 1);
        xfer(1, 1, g);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            if ((src_valid == '0) && ($urandom_range(0, 3) == 0)) begin
                step();
                chk("idle_ready", src_ready, 0);
                chk("idle_busy", busy, 0);
                chk("idle_req", mp_req, 0);
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!src_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    src_data[i*DW +: DW] = DW'($urandom);
                    src_valid[i] = 1'b1;
                end
            end
            if (src_valid == '0) begin
                src_data[0 +: DW] = DW'($urandom);
                src_valid[0] = 1'b1;
            end
            xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
